bcd_to_binary_seq: RTL and testbench

//  Sequential BCD-to-binary converter (reverse double-dabble). Accepts

---
 rtl/bcd_to_binary_seq_if.sv | 23 ++
 rtl/bcd_to_binary_seq.sv | 124 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if
//   Handshake/data bundle for the sequential BCD-to-binary converter.
//   start   : request conversion (requester -> converter)
//   bcd_in  : packed BCD operand, digit 0 in [3:0]
//   data    : binary result, held until the next result
//   busy    : conversion in progress
//   done    : one-cycle strobe, data/err valid
//   err     : captured operand contained a digit > 9
//   master  : requester side, slave : converter side
interface bcd_to_binary_seq_if #(
    parameter int NDIGITS = 9,
    parameter int NBITS   = 30
);
    logic                   start;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic [NBITS-1:0]       data;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (output start, bcd_in, input data, busy, done, err);
    modport slave  (input start, bcd_in, output data, busy, done, err);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter using reverse double-dabble. An
//   accepted start loads the operand, NBITS shift/correct iterations follow,
//   then the result is presented with a one-cycle done strobe. An operand
//   with any digit > 9 is rejected in one cycle with err set and data 0.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : bcd_to_binary_seq_if.slave (start, bcd_in, data, busy, done, err)
module bcd_to_binary_seq #(
    parameter int NDIGITS = 9,
    parameter int NBITS   = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_to_binary_seq_if.slave    bus
);
    localparam int BW = 4 * NDIGITS;
    localparam int WW = BW + NBITS;
    localparam int CW = $clog2(NBITS + 1);

    // Bits required to hold 10^nd - 1.
    function automatic int bits_needed(input int nd);
        logic [255:0] p;
        int           b;
        p = 256'd1;
        for (int i = 0; i < nd; i++) p = p * 256'd10;
        p = p - 256'd1;
        b = 0;
        while (p != 256'd0) begin
            p = p >> 1;
            b++;
        end
        return b;
    endfunction

    if (NDIGITS < 1 || NBITS < bits_needed(NDIGITS)) begin : g_param_err
        $error("bcd_to_binary_seq: NBITS too small for NDIGITS");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nx;
    logic [WW-1:0]      w, w_nx, corr;
    logic [CW-1:0]      count, count_nx;
    logic [NBITS-1:0]   data_r, data_nx;
    logic               done_r, done_nx;
    logic               err_r, err_nx;
    logic               bad_digit;

    // Operand validity: any nibble above 9 rejects the request.
    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < NDIGITS; d++)
            if (bus.bcd_in[4*d +: 4] > 4'd9) bad_digit = 1'b1;
    end

    // One reverse double-dabble step: shift right, then pull every BCD
    // digit that reached 8 or more back down by 3 (undoes the x2 carry of 10).
    always_comb begin
        corr = w >> 1;
        for (int d = 0; d < NDIGITS; d++)
            if (corr[NBITS + 4*d +: 4] >= 4'd8)
                corr[NBITS + 4*d +: 4] = corr[NBITS + 4*d +: 4] - 4'd3;
    end

    always_comb begin
        state_nx = state;
        w_nx     = w;
        count_nx = count;
        data_nx  = data_r;
        done_nx  = 1'b0;
        err_nx   = err_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bad_digit) begin
                        err_nx  = 1'b1;
                        data_nx = '0;
                        done_nx = 1'b1;
                    end else begin
                        w_nx     = {bus.bcd_in, {NBITS{1'b0}}};
                        err_nx   = 1'b0;
                        count_nx = '0;
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_nx     = corr;
                count_nx = count + 1'b1;
                if (count == CW'(NBITS - 1)) begin
                    data_nx  = corr[NBITS-1:0];
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            w      <= '0;
            count  <= '0;
            data_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            w      <= w_nx;
            count  <= count_nx;
            data_r <= data_nx;
            done_r <= done_nx;
            err_r  <= err_nx;
        end
    end

    assign bus.data = data_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
    assign bus.busy = (state == SHIFT);
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq
//   Scoreboard bench: expected {err, data} is pushed when a start is driven
//   and popped/compared when done strobes.
module tb_bcd_to_binary_seq;
    localparam int ND = 9;
    localparam int NB = 30;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic prev_done = 1'b0;
    logic [NB:0] exp_q[$];

    bcd_to_binary_seq_if #(.NDIGITS(ND), .NBITS(NB)) bif ();

    bcd_to_binary_seq #(.NDIGITS(ND), .NBITS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal accumulation of digits, MSD first.
    function automatic logic [NB:0] model(input logic [4*ND-1:0] b);
        longint v;
        logic   e;
        v = 0;
        e = 1'b0;
        for (int d = ND - 1; d >= 0; d--) begin
            if (b[4*d +: 4] > 4'd9) e = 1'b1;
            v = v * 10 + longint'(b[4*d +: 4]);
        end
        if (e) v = 0;
        return {e, v[NB-1:0]};
    endfunction

    always @(negedge clk) begin
        logic [NB:0] e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bif.done === 1'b1) begin
                chk("done_width", longint'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", longint'(bif.data), longint'(e[NB-1:0]));
                    chk("err", longint'(bif.err), longint'(e[NB]));
                end
            end
            prev_done = (bif.done === 1'b1);
        end
    end

    // Drive one start, then run until done; reports busy cycles and latency.
    task automatic conv(input logic [4*ND-1:0] b, output int bc, output int lat);
        bc  = 0;
        lat = -1;
        @(posedge clk); #1;
        bif.start  = 1'b1;
        bif.bcd_in = b;
        exp_q.push_back(model(b));
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            bif.start = 1'b0;
            if (bif.busy) bc++;
            if (bif.done) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("timeout_done", 0, 1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bif.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, longint'(seen), 1);
    endtask

    initial begin
        int bc, lat;
        rst        = 1'b0;
        bif.start  = 1'b0;
        bif.bcd_in = '0;

        // 1: asynchronous reset mid-cycle, then idle
        #13 rst = 1'b1;
        #1;
        chk("rst_outs", longint'({bif.data, bif.busy, bif.done, bif.err}), 0);
        #20 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_outs", longint'({bif.data, bif.busy, bif.done, bif.err}), 0);
        end

        // 2: basic conversion, timing
        conv(36'h000000123, bc, lat);
        chk("busy_cycles", bc, 30);
        chk("latency", lat, 31);
        chk("data_123", longint'(bif.data), 123);

        // 3: boundary operands
        conv(36'h999999999, bc, lat);
        chk("lat_max", lat, 31);
        chk("data_max", longint'(bif.data), 64'h3B9AC9FF);
        conv(36'h000000000, bc, lat);
        chk("lat_zero", lat, 31);
        @(posedge clk); #1;
        chk("done_drop", longint'(bif.done), 0);

        // 4: invalid digit, then recover
        conv(36'h00000001A, bc, lat);
        chk("err_lat", lat, 1);
        chk("err_busy", bc, 0);
        @(posedge clk); #1;
        chk("err_hold", longint'(bif.err), 1);
        conv(36'h000000042, bc, lat);
        chk("recover_lat", lat, 31);
        chk("recover_err", longint'(bif.err), 0);

        // 5: start while busy ignored; start in done cycle accepted
        @(posedge clk); #1;
        bif.start  = 1'b1;
        bif.bcd_in = 36'h000000500;
        exp_q.push_back(model(36'h000000500));
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bif.start  = 1'b1;
        bif.bcd_in = 36'h000000777;
        @(posedge clk); #1;
        bif.start = 1'b0;
        wait_done("done_500");
        chk("data_500", longint'(bif.data), 500);
        bif.start  = 1'b1;
        bif.bcd_in = 36'h000000321;
        exp_q.push_back(model(36'h000000321));
        @(posedge clk); #1;
        bif.start = 1'b0;
        chk("accept_in_done", longint'(bif.busy), 1);
        wait_done("done_321");

        // 6: reset mid-conversion aborts without done
        @(posedge clk); #1;
        bif.start  = 1'b1;
        bif.bcd_in = 36'h000000987;
        exp_q.push_back(model(36'h000000987));
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_outs", longint'({bif.data, bif.busy, bif.done, bif.err}), 0);
        #10 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_idle", longint'({bif.busy, bif.done}), 0);
        conv(36'h000065535, bc, lat);
        chk("lat_65535", lat, 31);
        chk("data_65535", longint'(bif.data), 65535);

        repeat (3) @(posedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
